// File: rtl/midi_pkg.sv
// MIDI shared definitions: status nibbles, parser and UART state encodings.
// Used by both the receive and transmit sides of the MIDI link.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF     = 4'h8;
  localparam logic [3:0] NOTE_ON      = 4'h9;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;

  typedef enum logic [1:0] {
    WAIT_STATUS,
    WAIT_NOTE,
    WAIT_VEL
  } parser_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } uart_state_t;

  function automatic logic is_note_status(input logic [7:0] b);
    return (b[7:4] == NOTE_OFF) || (b[7:4] == NOTE_ON);
  endfunction

endpackage

// File: rtl/midi_uart_in.sv
// MIDI serial receiver: 8N1 frames, LSB first, sampled at bit centres.
// Pulses byte_valid on a good stop bit, framing_error on a low one.
module midi_uart_in
  import midi_pkg::*;
#(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 31_250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       framing_error
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);

  uart_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          bv_d, fe_d;
  logic [2:0]    sync_q;
  logic          rx_s, fall;

  // sync_q[2] is the previous synchronised sample, for edge detection
  assign rx_s = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];
  assign data = shift_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q        <= 3'b111;
      state_q       <= RX_IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      byte_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      sync_q        <= {sync_q[1:0], rx};
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      byte_valid    <= bv_d;
      framing_error <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    bv_d    = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            bv_d    = 1'b1;
            state_d = RX_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) state_d = RX_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = RX_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/midi_note_receiver.sv
// MIDI-in front end: UART receive plus Note On/Off parser with
// running status; one event pulse per complete note message.
module midi_note_receiver
  import midi_pkg::*;
#(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 31_250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       event_valid,
  output logic       event_on,
  output logic [3:0] channel,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic       rx_error
);

  logic [7:0]    rx_byte;
  logic          byte_valid;
  logic          framing_error;

  parser_state_t state_q, state_d;
  logic [7:0]    status_q, status_d;
  logic [6:0]    note_q, note_d;
  logic          ev_d, on_d;
  logic [3:0]    ch_d;
  logic [6:0]    nt_d, vel_d;
  logic          is_rt, is_note, is_other, is_data;

  midi_uart_in #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_uart (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .data         (rx_byte),
    .byte_valid   (byte_valid),
    .framing_error(framing_error)
  );

  assign rx_error = framing_error;

  assign is_rt    = rx_byte >= REALTIME_MIN;
  assign is_note  = is_note_status(rx_byte);
  assign is_other = rx_byte[7] & ~is_rt & ~is_note;
  assign is_data  = ~rx_byte[7];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_STATUS;
      status_q    <= '0;
      note_q      <= '0;
      event_valid <= 1'b0;
      event_on    <= 1'b0;
      channel     <= '0;
      note        <= '0;
      velocity    <= '0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      note_q      <= note_d;
      event_valid <= ev_d;
      event_on    <= on_d;
      channel     <= ch_d;
      note        <= nt_d;
      velocity    <= vel_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    note_d   = note_q;
    ev_d     = 1'b0;
    on_d     = event_on;
    ch_d     = channel;
    nt_d     = note;
    vel_d    = velocity;
    if (byte_valid) begin
      unique case (1'b1)
        is_rt: ;
        is_note: begin
          status_d = rx_byte;
          state_d  = WAIT_NOTE;
        end
        is_other: begin
          status_d = '0;
          state_d  = WAIT_STATUS;
        end
        is_data: begin
          unique case (state_q)
            WAIT_NOTE: begin
              note_d  = rx_byte[6:0];
              state_d = WAIT_VEL;
            end
            WAIT_VEL: begin
              // Note On with velocity 0 is a Note Off
              ev_d    = 1'b1;
              on_d    = (status_q[7:4] == NOTE_ON) &&
                        (rx_byte[6:0] != 7'd0);
              ch_d    = status_q[3:0];
              nt_d    = note_q;
              vel_d   = rx_byte[6:0];
              state_d = WAIT_NOTE;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_midi_note_receiver.sv
// Self-checking bench for midi_note_receiver at 100 clks/bit:
// table vectors, hand-written corner sequences, random stream vs model.
module tb_midi_note_receiver;

  localparam int CLK_FREQ = 3_125_000;
  localparam int BAUD     = 31_250;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int GAP      = 20;

  typedef struct packed {
    logic       on;
    logic [3:0] ch;
    logic [6:0] nt;
    logic [6:0] vel;
  } ev_t;

  typedef struct {
    logic [7:0] b [6];
    int         n;
    int         n_ev;
    ev_t        ev;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       event_valid;
  logic       event_on;
  logic [3:0] channel;
  logic [6:0] note;
  logic [6:0] velocity;
  logic       rx_error;

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int bv_cnt = 0;
  int width_err = 0;
  int lat_err = 0;
  logic ev_prev = 1'b0;
  logic bv_prev = 1'b0;

  ev_t got_q [$];
  ev_t exp_q [$];
  vec_t vecs [7];

  logic       m_have = 1'b0;
  logic [7:0] m_status = 8'h00;
  logic [6:0] m_buf [$];

  midi_note_receiver #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .event_valid(event_valid),
    .event_on   (event_on),
    .channel    (channel),
    .note       (note),
    .velocity   (velocity),
    .rx_error   (rx_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (event_valid) begin
        got_q.push_back('{event_on, channel, note, velocity});
        if (ev_prev) width_err++;
        if (!bv_prev) lat_err++;
      end
      if (rx_error) err_cnt++;
      if (dut.u_uart.byte_valid) bv_cnt++;
    end
    ev_prev = event_valid;
    bv_prev = dut.u_uart.byte_valid;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  // Byte-level reference: a message is a note status followed by
  // pairs of data bytes; anything else just resets or is ignored.
  function automatic void model_feed(input logic [7:0] b);
    ev_t e;
    if (b >= 8'hF8) return;
    if (b[7]) begin
      m_have   = (b[7:4] == 4'h8) || (b[7:4] == 4'h9);
      m_status = b;
      m_buf.delete();
      return;
    end
    if (!m_have) return;
    m_buf.push_back(b[6:0]);
    if (m_buf.size() == 2) begin
      e.on  = (m_status[7:4] == 4'h9) && (m_buf[1] != 7'd0);
      e.ch  = m_status[3:0];
      e.nt  = m_buf[0];
      e.vel = m_buf[1];
      exp_q.push_back(e);
      m_buf.delete();
    end
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
    model_feed(b);
  endtask

  task automatic set_vec(input int i, input logic [7:0] b0, b1, b2,
                         b3, b4, input int n, input int nev,
                         input ev_t e);
    vecs[i].b[0] = b0;
    vecs[i].b[1] = b1;
    vecs[i].b[2] = b2;
    vecs[i].b[3] = b3;
    vecs[i].b[4] = b4;
    vecs[i].b[5] = 8'h00;
    vecs[i].n    = n;
    vecs[i].n_ev = nev;
    vecs[i].ev   = e;
  endtask

  task automatic apply_vec(input int i);
    got_q.delete();
    for (int k = 0; k < vecs[i].n; k++) send_byte(vecs[i].b[k]);
    exp_q.delete();
    repeat (5) @(negedge clk);
    check($sformatf("vec%0d count", i), got_q.size(), vecs[i].n_ev);
    if (got_q.size() > 0 && vecs[i].n_ev > 0) begin
      check($sformatf("vec%0d on", i), got_q[0].on, vecs[i].ev.on);
      check($sformatf("vec%0d ch", i), got_q[0].ch, vecs[i].ev.ch);
      check($sformatf("vec%0d note", i), got_q[0].nt, vecs[i].ev.nt);
      check($sformatf("vec%0d vel", i), got_q[0].vel, vecs[i].ev.vel);
    end
  endtask

  function automatic logic [7:0] rand_byte();
    int k;
    k = $urandom_range(0, 9);
    if (k <= 2) return {($urandom_range(0, 1) == 1) ? 4'h9 : 4'h8,
                        4'($urandom_range(0, 15))};
    if (k <= 7) return 8'($urandom_range(0, 127));
    if (k == 8) return 8'($urandom_range(248, 255));
    return 8'($urandom_range(160, 247));
  endfunction

  initial begin
    int e0, b0, nmin;
    set_vec(0, 8'h93, 8'h3C, 8'h64, 8'h00, 8'h00, 3, 1,
            '{1'b1, 4'd3, 7'd60, 7'd100});
    set_vec(1, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 2, 1,
            '{1'b0, 4'd3, 7'd64, 7'd0});
    set_vec(2, 8'h90, 8'h3C, 8'hF8, 8'h50, 8'h00, 4, 1,
            '{1'b1, 4'd0, 7'd60, 7'd80});
    set_vec(3, 8'h90, 8'h3C, 8'hB0, 8'h07, 8'h7F, 5, 0, '0);
    set_vec(4, 8'h3C, 8'h40, 8'h00, 8'h00, 8'h00, 2, 0, '0);
    set_vec(5, 8'h91, 8'h2A, 8'h00, 8'h00, 8'h00, 3, 1,
            '{1'b0, 4'd1, 7'd42, 7'd0});
    set_vec(6, 8'h85, 8'h30, 8'h10, 8'h00, 8'h00, 3, 1,
            '{1'b0, 4'd5, 7'd48, 7'd16});

    repeat (3) @(negedge clk);
    check("reset outputs",
          int'({event_valid, event_on, channel, note, velocity, rx_error}),
          0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 6; i++) apply_vec(i);

    // stop bit low: one error pulse, no byte
    e0 = err_cnt;
    b0 = bv_cnt;
    got_q.delete();
    send_frame(8'h90, 1'b0);
    repeat (10) @(negedge clk);
    check("bad stop err", err_cnt - e0, 1);
    check("bad stop byte", bv_cnt - b0, 0);

    // short low glitch: false start
    e0 = err_cnt;
    b0 = bv_cnt;
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch err", err_cnt - e0, 0);
    check("glitch byte", bv_cnt - b0, 0);
    check("glitch events", got_q.size(), 0);

    // reset during velocity data bits
    got_q.delete();
    send_byte(8'h93);
    send_byte(8'h3C);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = 8'(8'h64 >> i) & 8'h01 ? 1'b1 : 1'b0;
      repeat (CPB) @(negedge clk);
    end
    e0 = err_cnt;
    rx = 1'b1;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("mid reset outputs",
          int'({event_valid, event_on, channel, note, velocity, rx_error}),
          0);
    reset = 1'b0;
    repeat (8 * CPB) @(negedge clk);
    check("reset abort events", got_q.size(), 0);
    check("reset abort err", err_cnt - e0, 0);
    m_have = 1'b0;
    m_buf.delete();
    exp_q.delete();
    apply_vec(6);

    // random stream vs reference model
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 30; i++) send_byte(rand_byte());
    repeat (5) @(negedge clk);
    check("rand count", got_q.size(), exp_q.size());
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++)
      check($sformatf("rand ev%0d", i), int'(got_q[i]), int'(exp_q[i]));

    check("pulse width", width_err, 0);
    check("event latency", lat_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
